axis_interpolator: RTL and testbench

//  Upsampling counterpart of the stream decimator: each accepted AXI-Stream input

---
 rtl/axis_interpolator_pkg.sv | 13 +
 rtl/axis_interpolator.sv | 92 +++++++++
 tb/tb_axis_interpolator.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_interpolator_pkg.sv
// Package: axis_interpolator_pkg
// Shared type for the interpolator's output mode. The mode is captured with
// each accepted sample and selects how the R output beats are formed.
//   MODE_HOLD       : every beat carries the held sample (zero-order hold)
//   MODE_ZERO_STUFF : first beat carries the sample, the remaining R-1 are zero
package axis_interpolator_pkg;

    typedef enum logic {
        MODE_HOLD       = 1'b0,
        MODE_ZERO_STUFF = 1'b1
    } out_mode_e;

endpackage : axis_interpolator_pkg

// File: rtl/axis_interpolator.sv
// Module: axis_interpolator
// Upsampler for an AXI-Stream datapath. Each sample accepted on s00_axis is
// emitted R times on m_axis, R = cfg_data with 0 treated as 1. The output is
// either a repeat of the sample or the sample followed by R-1 zeros.
//
// Ports
//   aclk             in   system clock, rising edge
//   aresetn          in   asynchronous active-low reset
//   cfg_data         in   interpolation ratio R (0 => 1), sampled on accept
//   cfg_zero_stuff   in   1: zero-stuff, 0: hold; sampled on accept
//   s00_axis_tdata   in   input sample
//   s00_axis_tvalid  in   input valid
//   s00_axis_tready  out  input ready (combinational from m_axis_tready)
//   m_axis_tdata     out  output sample
//   m_axis_tvalid    out  output valid (registered)
//   m_axis_tready    in   output ready
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. Once m_axis_tvalid is raised, it and m_axis_tdata stay unchanged until
// that transfer; valid never depends on ready. s00_axis_tready may depend on
// m_axis_tready so that the last repeat and the next sample overlap in one
// cycle with no bubble.
module axis_interpolator
    import axis_interpolator_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic                        cfg_zero_stuff,
    input  logic [AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                        s00_axis_tvalid,
    output logic                        s00_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready
);

    logic [AXIS_TDATA_WIDTH-1:0] data_q;   // held sample
    logic                        valid_q;  // a burst is in progress
    logic [CNTR_WIDTH-1:0]       rem_q;    // beats left, including the one on the bus
    logic                        first_q;  // the beat on the bus is the first of its burst
    out_mode_e                   zs_q;     // mode captured with the held sample

    logic                  last;
    logic                  out_hs;
    logic                  accept;
    logic [CNTR_WIDTH-1:0] ratio;

    // A ratio of zero would otherwise mean "no output at all"; treat it as 1.
    assign ratio  = (cfg_data == '0) ? CNTR_WIDTH'(1) : cfg_data;

    assign last   = valid_q && (rem_q == CNTR_WIDTH'(1));
    assign out_hs = valid_q && m_axis_tready;

    // Ready when idle, or when the final repeat leaves on this very edge.
    assign s00_axis_tready = !valid_q || (last && m_axis_tready);
    assign accept          = s00_axis_tvalid && s00_axis_tready;

    assign m_axis_tvalid = valid_q;
    assign m_axis_tdata  = (zs_q == MODE_ZERO_STUFF && !first_q) ? '0 : data_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            rem_q   <= '0;
            first_q <= 1'b0;
            zs_q    <= MODE_HOLD;
        end else if (accept) begin
            // Accept has priority: when it coincides with the last beat
            // leaving, the new burst starts immediately.
            data_q  <= s00_axis_tdata;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            rem_q   <= ratio;
            zs_q    <= cfg_zero_stuff ? MODE_ZERO_STUFF : MODE_HOLD;
        end else if (out_hs) begin
            first_q <= 1'b0;
            if (last) begin
                valid_q <= 1'b0;
                rem_q   <= '0;
            end else begin
                // Only reached with rem_q > 1, so this never wraps.
                rem_q   <= rem_q - CNTR_WIDTH'(1);
            end
        end
    end

endmodule : axis_interpolator

// File: tb/tb_axis_interpolator.sv
// Bench for axis_interpolator. The reference model turns every accepted input
// into its list of expected output beats (R copies, or sample plus R-1 zeros)
// and checks the output stream and both ready/valid signals against that list.
module tb_axis_interpolator;

    localparam int W = 32;
    localparam int C = 32;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [C-1:0] cfg_data = '0;
    logic         cfg_zero_stuff = 1'b0;
    logic [W-1:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [W-1:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b1;

    axis_interpolator #(.AXIS_TDATA_WIDTH(W), .CNTR_WIDTH(C)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .cfg_data        (cfg_data),
        .cfg_zero_stuff  (cfg_zero_stuff),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready)
    );

    // ---------------- clock / cycle count ----------------
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];   // beats still owed by the DUT
    logic [W-1:0] out_log[$]; // beats actually transferred
    logic [W-1:0] want_q[$];  // expected contents of out_log for a directed test
    int           hs_cyc[$];
    int           acc_cyc[$];

    // Inputs change 1 time unit after the rising edge, so at the falling edge
    // everything is settled and the coming rising edge is fully predictable.
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
        end else begin
            check_eq("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                check_eq("m_tdata", 64'(m_tdata), 64'(exp_q[0]));
            check_eq("s_tready", 64'(s_tready),
                     64'((exp_q.size() == 0) || (exp_q.size() == 1 && m_tready)));
            if (m_tvalid && m_tready && exp_q.size() != 0) begin
                out_log.push_back(m_tdata);
                hs_cyc.push_back(cyc);
                void'(exp_q.pop_front());
            end
            if (s_tvalid && s_tready) begin
                int r;
                acc_cyc.push_back(cyc);
                r = (cfg_data == 0) ? 1 : int'(cfg_data);
                for (int k = 0; k < r; k++)
                    exp_q.push_back((cfg_zero_stuff && k > 0) ? '0 : s_tdata);
            end
        end
    end

    // ---------------- output ready driver ----------------
    bit rand_rdy = 1'b0;
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] d);
        int  n = 0;
        logic acc = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        while (!acc && n < 300) begin
            @(negedge aclk);
            acc = s_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        check_eq("send_accepted", 64'(acc), 64'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check_eq("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_logs();
        out_log.delete();
        hs_cyc.delete();
        acc_cyc.delete();
        want_q.delete();
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_len"}, 64'(out_log.size()), 64'(want_q.size()));
        for (int i = 0; i < want_q.size() && i < out_log.size(); i++)
            check_eq({tag, "_beat"}, 64'(out_log[i]), 64'(want_q[i]));
    endtask

    task automatic check_contiguous(input string tag);
        for (int i = 1; i < hs_cyc.size(); i++)
            check_eq({tag, "_gap"}, 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // reset state
        #2;
        check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("rst_tdata",  64'(m_tdata),  64'd0);
        check_eq("rst_tready", 64'(s_tready), 64'd1);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;

        // 1: R=4 hold, back-to-back, no gap, first beat one cycle after accept
        clear_logs();
        cfg_data = 4; cfg_zero_stuff = 1'b0;
        send(32'hA);
        send(32'hB);
        drain();
        want_q = '{32'hA, 32'hA, 32'hA, 32'hA, 32'hB, 32'hB, 32'hB, 32'hB};
        check_log("t1");
        check_contiguous("t1");
        if (acc_cyc.size() > 0 && hs_cyc.size() > 0)
            check_eq("t1_latency", 64'(hs_cyc[0] - acc_cyc[0]), 64'd1);
        else
            check_eq("t1_latency_seen", 64'd0, 64'd1);

        // 2: R=3 zero-stuff, input ready held low for 2 cycles per sample
        clear_logs();
        cfg_data = 3; cfg_zero_stuff = 1'b1;
        send(32'h5);
        send(32'h7);
        drain();
        want_q = '{32'h5, 32'h0, 32'h0, 32'h7, 32'h0, 32'h0};
        check_log("t2");
        if (acc_cyc.size() == 2)
            check_eq("t2_acc_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
        else
            check_eq("t2_acc_count", 64'(acc_cyc.size()), 64'd2);

        // 3: R=0 and R=1 pass-through at full rate, also in zero-stuff mode
        for (int rr = 0; rr < 2; rr++) begin
            clear_logs();
            cfg_data = C'(rr); cfg_zero_stuff = (rr == 1);
            send(32'h1);
            send(32'h2);
            send(32'h3);
            drain();
            want_q = '{32'h1, 32'h2, 32'h3};
            check_log("t3");
            check_contiguous("t3");
            if (acc_cyc.size() == 3) begin
                check_eq("t3_acc_rate", 64'(acc_cyc[2] - acc_cyc[0]), 64'd2);
                check_eq("t3_latency", 64'(hs_cyc.size() > 0 ? hs_cyc[0] - acc_cyc[0] : -1), 64'd1);
            end else
                check_eq("t3_acc_count", 64'(acc_cyc.size()), 64'd3);
        end

        // 4: R=4 with random output backpressure
        clear_logs();
        rand_rdy = 1'b1;
        cfg_data = 4; cfg_zero_stuff = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] d;
            d = $urandom;
            for (int k = 0; k < 4; k++) want_q.push_back(d);
            send(d);
        end
        drain();
        check_log("t4");

        // random ratio / mode / data / backpressure, checked by the scoreboard
        for (int i = 0; i < 40; i++) begin
            cfg_data = C'($urandom_range(0, 5));
            cfg_zero_stuff = 1'($urandom_range(0, 1));
            send($urandom);
            if ($urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge aclk);
                #1;
            end
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge aclk); #1;

        // 5: ratio changed mid-burst only affects the next sample
        clear_logs();
        cfg_data = 4; cfg_zero_stuff = 1'b0;
        send(32'h11);
        @(posedge aclk); #1;
        cfg_data = 2;
        send(32'h22);
        drain();
        want_q = '{32'h11, 32'h11, 32'h11, 32'h11, 32'h22, 32'h22};
        check_log("t5");

        // 6: async reset after 2 of 4 beats drops the rest
        clear_logs();
        cfg_data = 4; cfg_zero_stuff = 1'b0;
        send(32'h33);
        begin
            int n = 0;
            while (out_log.size() < 2 && n < 50) begin
                @(posedge aclk); #1; n++;
            end
        end
        #2 aresetn = 1'b0;
        #1;
        check_eq("t6_rst_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("t6_rst_tdata",  64'(m_tdata),  64'd0);
        check_eq("t6_rst_tready", 64'(s_tready), 64'd1);
        check_eq("t6_beats_before", 64'(out_log.size()), 64'd2);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        check_eq("t6_idle_tvalid", 64'(m_tvalid), 64'd0);
        clear_logs();
        send(32'h44);
        drain();
        want_q = '{32'h44, 32'h44, 32'h44, 32'h44};
        check_log("t6");

        repeat (2) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_axis_interpolator
